// File: rtl/memwb_pkg.sv
// memwb_pkg: shared types and constants for the MEM/WB write-back stage.
// Holds the RISC-V load funct3 encodings, the stored entry layout and the
// datapath width legality check used at elaboration time.
package memwb_pkg;

  // Widest datapath and register index an entry can carry
  localparam int ENTRY_XLEN = 64;
  localparam int ENTRY_RD_W = 5;

  // Only RV32 and RV64 datapaths are supported
  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;

  // RISC-V load funct3 encodings; encoding 7 is unused and yields zero
  typedef enum logic [2:0] {
    LOAD_LB  = 3'd0,
    LOAD_LH  = 3'd1,
    LOAD_LW  = 3'd2,
    LOAD_LD  = 3'd3,
    LOAD_LBU = 3'd4,
    LOAD_LHU = 3'd5,
    LOAD_LWU = 3'd6
  } load_type_e;

  // One write-back entry as held in the main or skid register
  typedef struct packed {
    logic                  reg_write;
    logic [ENTRY_RD_W-1:0] rd;
    logic [ENTRY_XLEN-1:0] data;
  } memwb_entry_t;

  // True when the datapath width is one the stage can be built for
  function automatic bit isLegalXlen(input int xlen);
    return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
  endfunction

endpackage

// File: rtl/memwb_stage_load_extend.sv
// load_extend: combinational byte-lane extraction and sign/zero extension
// of an aligned memory word for RISC-V loads. The word is shifted right by
// the byte offset (zeros enter from the top), then the low byte, half, word
// or full width is selected and extended according to funct3. On a 32-bit
// datapath LD and LWU behave exactly like LW.
module load_extend
  import memwb_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int OB  = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [OB-1:0]   offset_i,
  input  logic [2:0]      load_type_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wordSext;
  logic [XLEN-1:0] wordZext;

  assign shifted = data_i >> {offset_i, 3'b000};

  // Word extension only exists on a 64-bit datapath; on 32 bits it is a pass
  generate
    if (XLEN == XLEN_WIDE) begin : gWideWord
      assign wordSext = {{32{shifted[31]}}, shifted[31:0]};
      assign wordZext = {32'b0, shifted[31:0]};
    end else begin : gNarrowWord
      assign wordSext = shifted;
      assign wordZext = shifted;
    end
  endgenerate

  // Select and extend the addressed lane according to the load funct3
  always_comb begin
    data_o = '0;
    case (load_type_e'(load_type_i))
      LOAD_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LOAD_LH:  data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LOAD_LW:  data_o = wordSext;
      LOAD_LD:  data_o = (XLEN == XLEN_WIDE) ? shifted : wordSext;
      LOAD_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LOAD_LHU: data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LOAD_LWU: data_o = (XLEN == XLEN_WIDE) ? wordZext : wordSext;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline stage with valid/ready handshake and a
// two-entry (main + skid) buffer. The write-back value is resolved on the
// input path (load extension or ALU result) and registered. Writes to x0
// are never qualified on out_reg_write.
// Optional feature: define MEMWB_FWD_EN to drive the fwd_* bypass port from
// the main entry; otherwise fwd_* are tied to zero.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [2:0]        in_load_type,
  input  logic [XLEN-1:0]   in_read_data,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int OB = $clog2(XLEN / 8);

  // Refuse to elaborate for a width the entry layout cannot hold
  generate
    if (!isLegalXlen(XLEN) || (REG_AW > ENTRY_RD_W)) begin : gBadConfig
      $error("memwb_stage: XLEN must be 32 or 64 and REG_AW must fit the entry");
    end
  endgenerate

  logic [XLEN-1:0] extData;
  memwb_entry_t    newEntry;
  memwb_entry_t    mainEntry_q, mainEntry_d;
  memwb_entry_t    skidEntry_q, skidEntry_d;
  logic            mainValid_q, mainValid_d;
  logic            skidValid_q, skidValid_d;
  logic            accept;
  logic            drain;

  load_extend #(
    .XLEN(XLEN)
  ) uLoadExtend (
    .data_i     (in_read_data),
    .offset_i   (in_alu_result[OB-1:0]),
    .load_type_i(in_load_type),
    .data_o     (extData)
  );

  // Build the entry to store: final write-back value chosen at input time
  always_comb begin
    newEntry                 = '0;
    newEntry.reg_write       = in_reg_write;
    newEntry.rd[REG_AW-1:0]  = in_rd;
    newEntry.data[XLEN-1:0]  = in_mem_to_reg ? extData : in_alu_result;
  end

  assign accept = in_valid & ~skidValid_q;
  assign drain  = mainValid_q & out_ready;

  // Next-state of the main/skid pair; flush wins over accept and drain
  always_comb begin
    mainEntry_d = mainEntry_q;
    skidEntry_d = skidEntry_q;
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (skidValid_q) begin
      if (drain) begin
        mainEntry_d = skidEntry_q;
        mainValid_d = 1'b1;
        skidValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!mainValid_q || drain) begin
        mainEntry_d = newEntry;
        mainValid_d = 1'b1;
      end else begin
        skidEntry_d = newEntry;
        skidValid_d = 1'b1;
      end
    end else if (drain) begin
      mainValid_d = 1'b0;
    end
  end

  // Storage registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainEntry_q <= '0;
      skidEntry_q <= '0;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
    end
  end

  assign in_ready      = ~skidValid_q;
  assign out_valid     = mainValid_q;
  assign out_rd        = mainEntry_q.rd[REG_AW-1:0];
  assign out_data      = mainEntry_q.data[XLEN-1:0];
  assign out_reg_write = mainValid_q & mainEntry_q.reg_write & (out_rd != '0);

`ifdef MEMWB_FWD_EN
  assign fwd_valid = out_reg_write;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// tb_memwb_stage: directed, table-driven bench for memwb_stage (XLEN=64).
// Single-transaction vectors run back to back with out_ready held high, then
// hand-written sequences cover skid fill/drain order, flush and async reset.
module tb_memwb_stage;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

`ifdef MEMWB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic [2:0]        in_load_type;
  logic [XLEN-1:0]   in_read_data;
  logic [XLEN-1:0]   in_alu_result;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_data;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;

  typedef struct {
    string       name;
    logic        memToReg;
    logic        regWrite;
    logic [2:0]  loadType;
    logic [63:0] readData;
    logic [63:0] aluResult;
    logic [4:0]  rd;
    logic        expRegWrite;
    logic [63:0] expData;
  } vector_t;

  localparam int NUM_VEC = 14;
  vector_t vectors[NUM_VEC];

  int checks   = 0;
  int failures = 0;

  memwb_stage #(
    .XLEN  (XLEN),
    .REG_AW(REG_AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_to_reg(in_mem_to_reg),
    .in_reg_write (in_reg_write),
    .in_load_type (in_load_type),
    .in_read_data (in_read_data),
    .in_alu_result(in_alu_result),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_reg_write(out_reg_write),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    in_valid      = 1'b1;
    in_mem_to_reg = v.memToReg;
    in_reg_write  = v.regWrite;
    in_load_type  = v.loadType;
    in_read_data  = v.readData;
    in_alu_result = v.aluResult;
    in_rd         = v.rd;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Full check of a valid main entry including the forwarding port
  task automatic checkEntry(input string tag, input logic expRw,
                            input logic [4:0] expRd, input logic [63:0] expData);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_rw"}, 64'(out_reg_write), 64'(expRw));
    checkOutput({tag, "_rd"}, 64'(out_rd), 64'(expRd));
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_fwdv"}, 64'(fwd_valid), FWD_ON ? 64'(expRw) : 64'd0);
    checkOutput({tag, "_fwdrd"}, 64'(fwd_rd), FWD_ON ? 64'(expRd) : 64'd0);
    checkOutput({tag, "_fwdd"}, fwd_data, FWD_ON ? expData : 64'd0);
  endtask

  function automatic vector_t aluVec(input string name, input logic [63:0] value,
                                     input logic [4:0] rd);
    vector_t v;
    v.name        = name;
    v.memToReg    = 1'b0;
    v.regWrite    = 1'b1;
    v.loadType    = 3'd0;
    v.readData    = 64'h0;
    v.aluResult   = value;
    v.rd          = rd;
    v.expRegWrite = (rd != 5'd0);
    v.expData     = value;
    return v;
  endfunction

  initial begin
    vector_t a, b, c;

    vectors[0]  = '{"lb_neg",    1'b1, 1'b1, 3'd0, 64'h1122_3344_80FF_0000, 64'h1003, 5'd7,  1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vectors[1]  = '{"lbu",       1'b1, 1'b1, 3'd4, 64'h1122_3344_80FF_0000, 64'h1003, 5'd7,  1'b1, 64'h0000_0000_0000_0080};
    vectors[2]  = '{"alu_x0",    1'b0, 1'b1, 3'd0, 64'h0,                   64'h1234, 5'd0,  1'b0, 64'h0000_0000_0000_1234};
    vectors[3]  = '{"lh_neg",    1'b1, 1'b1, 3'd1, 64'h8001_0000_0000_0000, 64'h2006, 5'd3,  1'b1, 64'hFFFF_FFFF_FFFF_8001};
    vectors[4]  = '{"lhu",       1'b1, 1'b1, 3'd5, 64'h8001_0000_0000_0000, 64'h2006, 5'd3,  1'b1, 64'h0000_0000_0000_8001};
    vectors[5]  = '{"lw_neg",    1'b1, 1'b1, 3'd2, 64'h8765_4321_0000_0000, 64'h0004, 5'd10, 1'b1, 64'hFFFF_FFFF_8765_4321};
    vectors[6]  = '{"lwu",       1'b1, 1'b1, 3'd6, 64'h8765_4321_0000_0000, 64'h0004, 5'd10, 1'b1, 64'h0000_0000_8765_4321};
    vectors[7]  = '{"ld",        1'b1, 1'b1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000, 5'd31, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
    vectors[8]  = '{"ld_mis",    1'b1, 1'b1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0002, 5'd31, 1'b1, 64'h0000_DEAD_BEEF_CAFE};
    vectors[9]  = '{"funct3_7",  1'b1, 1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000, 5'd12, 1'b1, 64'h0};
    vectors[10] = '{"lb_pos_hi", 1'b1, 1'b1, 3'd0, 64'h7F00_0000_0000_0000, 64'h0007, 5'd13, 1'b1, 64'h0000_0000_0000_007F};
    vectors[11] = '{"lh_top",    1'b1, 1'b1, 3'd1, 64'hAB00_0000_0000_0000, 64'h0007, 5'd14, 1'b1, 64'h0000_0000_0000_00AB};
    vectors[12] = '{"no_rw",     1'b0, 1'b0, 3'd0, 64'h0,                   64'h5555, 5'd9,  1'b0, 64'h0000_0000_0000_5555};
    vectors[13] = '{"lw_fwd",    1'b1, 1'b1, 3'd2, 64'h0000_0000_8000_0000, 64'h0000, 5'd5,  1'b1, 64'hFFFF_FFFF_8000_0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_load_type = 3'd0;
    in_read_data = '0; in_alu_result = '0; in_rd = '0;

    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_rw", 64'(out_reg_write), 64'd0);
    checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    checkOutput("rst_fwd_rd", 64'(fwd_rd), 64'd0);
    checkOutput("rst_fwd_data", fwd_data, 64'd0);

    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // Back-to-back single transactions, one accept per cycle
    out_ready = 1'b1;
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i]);
      stepCycle();
      in_valid = 1'b0;
      checkEntry(vectors[i].name, vectors[i].expRegWrite, vectors[i].rd, vectors[i].expData);
    end
    stepCycle();
    checkOutput("vec_drained", 64'(out_valid), 64'd0);

    // Skid fill with out_ready low, then drain in order A, B, C
    a = aluVec("A", 64'hAAAA, 5'd1);
    b = aluVec("B", 64'hBBBB, 5'd2);
    c = aluVec("C", 64'hCCCC, 5'd3);
    out_ready = 1'b0;
    applyStimulus(a);
    stepCycle();
    checkOutput("skid_a_ready", 64'(in_ready), 64'd1);
    checkOutput("skid_a_data", out_data, 64'hAAAA);
    applyStimulus(b);
    stepCycle();
    checkOutput("skid_b_ready", 64'(in_ready), 64'd0);
    checkOutput("skid_b_main", out_data, 64'hAAAA);
    applyStimulus(c);
    stepCycle();
    checkOutput("skid_c_held_ready", 64'(in_ready), 64'd0);
    checkOutput("skid_c_held_main", out_data, 64'hAAAA);
    checkOutput("skid_c_held_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("skid_out_b", out_data, 64'hBBBB);
    checkOutput("skid_out_b_ready", 64'(in_ready), 64'd1);
    stepCycle();
    in_valid = 1'b0;
    checkEntry("skid_out_c", 1'b1, 5'd3, 64'hCCCC);
    checkOutput("skid_out_c_ready", 64'(in_ready), 64'd1);
    stepCycle();
    checkOutput("skid_empty", 64'(out_valid), 64'd0);

    // Flush with both entries full and a new entry presented
    out_ready = 1'b0;
    applyStimulus(aluVec("F1", 64'h111, 5'd2));
    stepCycle();
    applyStimulus(aluVec("F2", 64'h222, 5'd3));
    stepCycle();
    checkOutput("flush_full_ready", 64'(in_ready), 64'd0);
    applyStimulus(aluVec("F3", 64'h333, 5'd4));
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_rw", 64'(out_reg_write), 64'd0);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("flush_dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with both entries occupied
    out_ready = 1'b0;
    applyStimulus(aluVec("R1", 64'h555, 5'd6));
    stepCycle();
    applyStimulus(aluVec("R2", 64'h666, 5'd8));
    stepCycle();
    in_valid = 1'b0;
    checkOutput("arst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    checkOutput("arst_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_data", out_data, 64'd0);
    #1;
    rst_n = 1'b1;
    stepCycle();
    out_ready = 1'b1;
    applyStimulus(aluVec("R3", 64'h777, 5'd7));
    stepCycle();
    in_valid = 1'b0;
    checkEntry("arst_first", 1'b1, 5'd7, 64'h777);
    stepCycle();
    checkOutput("arst_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
